// File: rtl/muldiv_sequencer_if.sv
// Bundle between the EX stage, the hazard unit, the mult/div units and the
// sequencer. Handshake: a request is taken in IDLE when (start_mult_E |
// start_div_E) & !flush_E & !abort_i; the units see a one-cycle start pulse,
// the multiplier answers after a fixed latency, the divider with a one-cycle
// div_done pulse; the sequencer answers the pipeline with a one-cycle
// result_valid_o while stall_o holds the pipeline until then.
interface muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_mult_E;
    logic                  start_div_E;
    logic [1:0]            mult_func_E;
    logic [1:0]            div_func_E;
    logic [4:0]            rd_E;
    logic                  flush_E;
    logic                  abort_i;
    logic                  mult_start;
    logic [1:0]            mult_func;
    logic [DATA_WIDTH-1:0] mult_result;
    logic                  div_start;
    logic [1:0]            div_func;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_result;
    logic                  stall_o;
    logic                  result_valid_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic [4:0]            result_rd_o;
    logic                  busy_o;
    logic                  err_o;
    logic [1:0]            state_dbg;

    // Sequencer side
    modport master (
        input  start_mult_E, start_div_E, mult_func_E, div_func_E, rd_E,
        input  flush_E, abort_i, mult_result, div_done, div_result,
        output mult_start, mult_func, div_start, div_func,
        output stall_o, result_valid_o, result_o, result_rd_o, busy_o, err_o,
        output state_dbg
    );

    // Pipeline / unit side
    modport slave (
        output start_mult_E, start_div_E, mult_func_E, div_func_E, rd_E,
        output flush_E, abort_i, mult_result, div_done, div_result,
        input  mult_start, mult_func, div_start, div_func,
        input  stall_o, result_valid_o, result_o, result_rd_o, busy_o, err_o,
        input  state_dbg
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Issues start pulses to the multi-cycle multiplier/divider for the EX
// instruction, stalls the pipeline while the unit works, and presents the
// captured result with its destination register for one cycle.
module muldiv_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    muldiv_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MUL_LOAD  = CNT_WIDTH'(MULT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] DIV_LIMIT = CNT_WIDTH'(DIV_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  req_ok;
    logic                  mult_start_q;
    logic                  div_start_q;
    logic [1:0]            mult_func_q;
    logic [1:0]            div_func_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [4:0]            rd_q;
    logic                  err_q;

    // Abort in IDLE suppresses acceptance just like a flush; the reset term
    // keeps stall_o low while rst_n is asserted whatever the inputs do.
    assign req_ok  = rst_n & (bus.start_mult_E | bus.start_div_E) &
                     ~bus.flush_E & ~bus.abort_i;
    assign cnt_inc = cnt + CNT_ONE;

    // Single FSM: request capture, unit sequencing, result capture, timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            mult_func_q  <= '0;
            div_func_q   <= '0;
            valid_q      <= 1'b0;
            result_q     <= '0;
            rd_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            valid_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        rd_q <= bus.rd_E;
                        // Both starts high is an illegal decode; multiply wins
                        if (bus.start_mult_E) begin
                            mult_func_q  <= bus.mult_func_E;
                            mult_start_q <= 1'b1;
                            cnt          <= MUL_LOAD;
                            state        <= MUL_WAIT;
                        end else begin
                            div_func_q  <= bus.div_func_E;
                            div_start_q <= 1'b1;
                            cnt         <= '0;
                            state       <= DIV_WAIT;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (bus.abort_i) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        result_q <= bus.mult_result;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DIV_WAIT: begin
                    if (bus.abort_i) begin
                        state <= IDLE;
                    end else if (bus.div_done) begin
                        result_q <= bus.div_result;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end else if (cnt_inc == DIV_LIMIT) begin
                        // Divider never answered: return all ones, flag it
                        cnt      <= cnt_inc;
                        err_q    <= 1'b1;
                        result_q <= '1;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    // EX still holds the same instruction; do not re-accept it
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mult_start     = mult_start_q;
    assign bus.mult_func      = mult_func_q;
    assign bus.div_start      = div_start_q;
    assign bus.div_func       = div_func_q;
    assign bus.result_valid_o = valid_q;
    assign bus.result_o       = result_q;
    assign bus.result_rd_o    = rd_q;
    assign bus.err_o          = err_q;
    assign bus.busy_o         = (state != IDLE);
    assign bus.state_dbg      = state;
    assign bus.stall_o        = (state == MUL_WAIT) | (state == DIV_WAIT) |
                                ((state == IDLE) & req_ok);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (MULT_CYCLES=4, DIV_TIMEOUT=64).
module tb_muldiv_sequencer;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    muldiv_sequencer_if #(.DATA_WIDTH(32)) bus ();

    muldiv_sequencer #(
        .DATA_WIDTH (32),
        .MULT_CYCLES(4),
        .DIV_TIMEOUT(64),
        .CNT_WIDTH  (7)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to 2 time units after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.start_mult_E = 1'b0;
        bus.start_div_E  = 1'b0;
        bus.flush_E      = 1'b0;
        bus.abort_i      = 1'b0;
        bus.div_done     = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        idle_inputs();
        bus.mult_func_E = 2'd0;
        bus.div_func_E  = 2'd0;
        bus.rd_E        = 5'd0;
        bus.mult_result = 32'h0;
        bus.div_result  = 32'h0;

        // Reset state
        #1;
        chk1 ("rst_stall", bus.stall_o, 1'b0);
        chk1 ("rst_busy", bus.busy_o, 1'b0);
        chk1 ("rst_valid", bus.result_valid_o, 1'b0);
        chk32("rst_result", bus.result_o, 32'h0);
        chk1 ("rst_err", bus.err_o, 1'b0);
        chk32("rst_state", 32'(bus.state_dbg), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // 1. Multiply: request cycle 0, result at cycle 5, valid cycle 6
        step();
        bus.start_mult_E = 1'b1; bus.mult_func_E = 2'd2; bus.rd_E = 5'd5;
        #1;
        chk1("m_c0_stall", bus.stall_o, 1'b1);
        chk1("m_c0_mstart", bus.mult_start, 1'b0);
        step();
        bus.start_mult_E = 1'b0; bus.rd_E = 5'd0;
        #1;
        chk1 ("m_c1_mstart", bus.mult_start, 1'b1);
        chk1 ("m_c1_stall", bus.stall_o, 1'b1);
        chk1 ("m_c1_busy", bus.busy_o, 1'b1);
        chk32("m_c1_func", 32'(bus.mult_func), 32'd2);
        for (int c = 2; c <= 4; c++) begin
            step(); #1;
            chk1("m_mid_mstart", bus.mult_start, 1'b0);
            chk1("m_mid_stall", bus.stall_o, 1'b1);
        end
        step();
        bus.mult_result = 32'h0000_0030;
        #1;
        chk1("m_c5_stall", bus.stall_o, 1'b1);
        chk1("m_c5_valid", bus.result_valid_o, 1'b0);
        step();
        bus.mult_result = 32'hDEAD_BEEF;
        #1;
        chk1 ("m_c6_valid", bus.result_valid_o, 1'b1);
        chk32("m_c6_result", bus.result_o, 32'h30);
        chk32("m_c6_rd", 32'(bus.result_rd_o), 32'd5);
        chk1 ("m_c6_stall", bus.stall_o, 1'b0);
        step(); #1;
        chk1 ("m_c7_busy", bus.busy_o, 1'b0);
        chk1 ("m_c7_valid", bus.result_valid_o, 1'b0);
        chk32("m_c7_hold", bus.result_o, 32'h30);

        // 2. Divide: done at cycle 10, valid cycle 11
        step();
        bus.start_div_E = 1'b1; bus.div_func_E = 2'd1; bus.rd_E = 5'd9;
        #1;
        chk1("d_c0_stall", bus.stall_o, 1'b1);
        step();
        bus.start_div_E = 1'b0;
        #1;
        chk1 ("d_c1_dstart", bus.div_start, 1'b1);
        chk1 ("d_c1_mstart", bus.mult_start, 1'b0);
        chk32("d_c1_func", 32'(bus.div_func), 32'd1);
        for (int c = 2; c <= 9; c++) begin
            step(); #1;
            chk1("d_mid_stall", bus.stall_o, 1'b1);
            chk1("d_mid_dstart", bus.div_start, 1'b0);
        end
        step();
        bus.div_done = 1'b1; bus.div_result = 32'd7;
        #1;
        chk1("d_c10_stall", bus.stall_o, 1'b1);
        step();
        bus.div_done = 1'b0; bus.div_result = 32'h0;
        #1;
        chk1 ("d_c11_valid", bus.result_valid_o, 1'b1);
        chk32("d_c11_result", bus.result_o, 32'd7);
        chk32("d_c11_rd", 32'(bus.result_rd_o), 32'd9);
        chk1 ("d_c11_err", bus.err_o, 1'b0);
        chk1 ("d_c11_stall", bus.stall_o, 1'b0);
        step(); #1;
        chk1("d_c12_busy", bus.busy_o, 1'b0);

        // 3. Divide timeout: 64 DIV_WAIT cycles, DONE at cycle 65
        step();
        bus.start_div_E = 1'b1; bus.rd_E = 5'd3;
        #1;
        step();
        bus.start_div_E = 1'b0;
        #1;
        for (int c = 1; c <= 64; c++) begin
            if (c > 1) begin
                step(); #1;
            end
            chk1("t_wait_stall", bus.stall_o, 1'b1);
            chk1("t_wait_valid", bus.result_valid_o, 1'b0);
        end
        step(); #1;
        chk1 ("t_done_valid", bus.result_valid_o, 1'b1);
        chk32("t_done_result", bus.result_o, 32'hFFFF_FFFF);
        chk1 ("t_done_err", bus.err_o, 1'b1);
        chk32("t_done_rd", 32'(bus.result_rd_o), 32'd3);
        step(); #1;
        chk1("t_after_busy", bus.busy_o, 1'b0);
        chk1("t_after_err", bus.err_o, 1'b1);

        // 4a. Flushed request is not accepted
        step();
        bus.start_mult_E = 1'b1; bus.flush_E = 1'b1;
        #1;
        chk1("f_stall", bus.stall_o, 1'b0);
        step();
        idle_inputs();
        #1;
        chk1("f_mstart", bus.mult_start, 1'b0);
        chk1("f_busy", bus.busy_o, 1'b0);

        // 4b. Abort multiply at cycle 3, IDLE at cycle 4, no result
        step();
        bus.start_mult_E = 1'b1; bus.rd_E = 5'd6;
        #1;
        step();
        bus.start_mult_E = 1'b0;
        step();
        step();
        bus.abort_i = 1'b1;
        #1;
        chk1("a_c3_stall", bus.stall_o, 1'b1);
        step();
        bus.abort_i = 1'b0;
        #1;
        chk1("a_c4_busy", bus.busy_o, 1'b0);
        chk1("a_c4_stall", bus.stall_o, 1'b0);
        for (int c = 5; c <= 8; c++) begin
            step(); #1;
            chk1("a_novalid", bus.result_valid_o, 1'b0);
        end
        chk32("a_hold", bus.result_o, 32'hFFFF_FFFF);

        // 4c. Abort divide, then a late div_done in IDLE is ignored
        step();
        bus.start_div_E = 1'b1; bus.rd_E = 5'd7;
        #1;
        step();
        bus.start_div_E = 1'b0;
        step();
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        step();
        bus.div_done = 1'b1; bus.div_result = 32'h55;
        #1;
        chk1("l_idle_busy", bus.busy_o, 1'b0);
        step();
        bus.div_done = 1'b0;
        #1;
        chk1 ("l_novalid", bus.result_valid_o, 1'b0);
        chk32("l_hold", bus.result_o, 32'hFFFF_FFFF);
        chk1 ("l_busy", bus.busy_o, 1'b0);

        // 5a. Back-to-back: multiply held in EX through DONE, divide next
        step();
        bus.start_mult_E = 1'b1; bus.mult_func_E = 2'd1; bus.rd_E = 5'd10;
        for (int c = 1; c <= 5; c++) step();
        bus.mult_result = 32'h1234;
        step();
        #1;
        chk1 ("b_m_valid", bus.result_valid_o, 1'b1);
        chk32("b_m_result", bus.result_o, 32'h1234);
        chk32("b_m_rd", 32'(bus.result_rd_o), 32'd10);
        chk1 ("b_m_stall", bus.stall_o, 1'b0);
        step();
        bus.start_mult_E = 1'b0; bus.start_div_E = 1'b1; bus.rd_E = 5'd11;
        #1;
        chk1("b_d_accept_stall", bus.stall_o, 1'b1);
        chk1("b_d_accept_busy", bus.busy_o, 1'b0);
        step(); #1;
        chk1("b_d_dstart", bus.div_start, 1'b1);
        chk1("b_d_mstart", bus.mult_start, 1'b0);
        step();
        bus.div_done = 1'b1; bus.div_result = 32'h99;
        step();
        bus.div_done = 1'b0;
        #1;
        chk1 ("b_d_valid", bus.result_valid_o, 1'b1);
        chk32("b_d_result", bus.result_o, 32'h99);
        chk32("b_d_rd", 32'(bus.result_rd_o), 32'd11);
        step();
        bus.start_div_E = 1'b0;
        #1;
        chk1("b_end_valid", bus.result_valid_o, 1'b0);
        chk1("b_end_busy", bus.busy_o, 1'b0);

        // 5b. Both starts high: multiply wins
        step();
        bus.start_mult_E = 1'b1; bus.start_div_E = 1'b1; bus.rd_E = 5'd12;
        #1;
        chk1("p_stall", bus.stall_o, 1'b1);
        step();
        bus.start_mult_E = 1'b0; bus.start_div_E = 1'b0;
        #1;
        chk1("p_mstart", bus.mult_start, 1'b1);
        chk1("p_dstart", bus.div_start, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            step(); #1;
            chk1("p_dstart_mid", bus.div_start, 1'b0);
        end
        step();
        bus.mult_result = 32'h42;
        step();
        #1;
        chk1 ("p_valid", bus.result_valid_o, 1'b1);
        chk32("p_result", bus.result_o, 32'h42);
        chk32("p_rd", 32'(bus.result_rd_o), 32'd12);
        step();

        // 6. Asynchronous reset during DIV_WAIT
        step();
        bus.start_div_E = 1'b1; bus.div_func_E = 2'd3; bus.rd_E = 5'd13;
        step();
        bus.start_div_E = 1'b0;
        step();
        #1;
        chk1("r_pre_busy", bus.busy_o, 1'b1);
        chk1("r_pre_err", bus.err_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1 ("r_busy", bus.busy_o, 1'b0);
        chk1 ("r_stall", bus.stall_o, 1'b0);
        chk1 ("r_err", bus.err_o, 1'b0);
        chk32("r_result", bus.result_o, 32'h0);
        chk32("r_rd", 32'(bus.result_rd_o), 32'd0);
        chk32("r_dfunc", 32'(bus.div_func), 32'd0);
        chk32("r_mfunc", 32'(bus.mult_func), 32'd0);
        chk1 ("r_valid", bus.result_valid_o, 1'b0);
        step();
        rst_n = 1'b1;
        step(); #1;
        chk32("r_state", 32'(bus.state_dbg), 32'd0);
        chk1 ("r_after_busy", bus.busy_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Sequences the multi-cycle multiplier and divider units on behalf of the EX stage. It takes the registered start_mult/start_div/func controls of the instruction in EX and issues a one-cycle start pulse to the selected unit. It stalls the pipeline until the result is captured, then presents the result with its destination register for one cycle. It sits between the EX pipeline register and the mult/div units, and feeds the hazard unit's stall and flush logic.

Parameters:
DATA_WIDTH, 32, operand/result width
MULT_CYCLES, 4, fixed multiplier latency in cycles from mult_start to a valid mult_result (must be >=1)
DIV_TIMEOUT, 64, maximum cycles waited for div_done before error abort
CNT_WIDTH, 7, counter width; must hold max(MULT_CYCLES, DIV_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_mult_E  in  1  EX instruction is a multiply
start_div_E  in  1  EX instruction is a divide/remainder
mult_func_E  in  2  multiply variant
div_func_E  in  2  divide variant
rd_E  in  5  destination register of the EX instruction
flush_E  in  1  EX instruction is being squashed this cycle
abort_i  in  1  trap/exception kill of any in-flight operation
mult_start  out  1  one-cycle start pulse to the multiplier
mult_func  out  2  held multiply variant
mult_result  in  DATA_WIDTH  multiplier output
div_start  out  1  one-cycle start pulse to the divider
div_func  out  2  held divide variant
div_done  in  1  divider result valid (single-cycle pulse)
div_result  in  DATA_WIDTH  divider output
stall_o  out  1  freeze PC, IF/ID and ID/EX registers
result_valid_o  out  1  result and result_rd are valid this cycle
result_o  out  DATA_WIDTH  captured result
result_rd_o  out  5  destination register of the result
busy_o  out  1  state is not IDLE
err_o  out  1  sticky divider timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. All outputs are 0: mult/div_start, mult/div_func, stall_o, result_valid_o, result_o, result_rd_o, busy_o, err_o.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE:
  - A request is valid when (start_mult_E|start_div_E) & !flush_E. Otherwise the state stays IDLE and no stall is raised.
  - If start_mult_E and start_div_E are both high, the multiply wins (illegal decode).
  - On a valid request, stall_o=1 combinationally in the same cycle T.
  - The request registers rd_E into result_rd_o and the func into mult_func or div_func.
  - A multiply goes to MUL_WAIT with counter=MULT_CYCLES. A divide goes to DIV_WAIT with counter=0.
- MUL_WAIT:
  - mult_start=1 only in the first cycle (T+1). The counter decrements every cycle.
  - When counter==0 (cycle T+1+MULT_CYCLES), mult_result is captured into result_o and the state goes to DONE.
  - stall_o=1 throughout.
- DIV_WAIT:
  - div_start=1 only in the first cycle (T+1). The counter increments every cycle.
  - When div_done=1, div_result is captured and the state goes to DONE.
  - If the counter reaches DIV_TIMEOUT without div_done: err_o is set (sticky until reset), result_o is set to all ones, and the state goes to DONE.
  - stall_o=1 throughout.
- DONE:
  - result_valid_o=1 for exactly one cycle and stall_o=0, so the instruction advances.
  - Start inputs are ignored in DONE because the EX instruction is still the same one. Next state is IDLE.
  - Back-to-back mul/div: earliest new acceptance is the cycle after DONE.
- abort_i in MUL_WAIT or DIV_WAIT:
  - Next state is IDLE, no result_valid_o, stall_o drops the next cycle.
  - A late div_done in IDLE is ignored.
  - abort_i in IDLE or DONE has no effect, except that in IDLE it suppresses acceptance like flush_E.
- flush_E is ignored outside IDLE, because the EX stage is frozen by the stall.
- result_o and result_rd_o hold their values until the next capture.
- busy_o = (state != IDLE).
- Counter arithmetic is unsigned with no wrap: the MUL count stops at 0, and the DIV count stops at DIV_TIMEOUT.

Test Plan:
1. Multiply, MULT_CYCLES=4, start_mult_E=1 at cycle 0, rd_E=5, mult_result=0x0000_0030 at cycle 5 -> stall_o high cycles 0-5, mult_start high cycle 1 only, result_valid_o high cycle 6 with result_o=0x30 and result_rd_o=5, busy_o low cycle 7.
2. Divide: start_div_E at cycle 0, div_done with div_result=7 at cycle 10 -> div_start at cycle 1, stall_o high cycles 0-10, result_valid_o high cycle 11 with result_o=7, err_o=0.
3. Divide timeout: div_done never asserted, DIV_TIMEOUT=64 -> transition to DONE after 64 DIV_WAIT cycles, result_o=0xFFFF_FFFF, err_o=1 and stays 1 until rst_n pulse.
4. Flush and abort:
   - start_mult_E=1 with flush_E=1 -> no stall, no mult_start.
   - abort_i=1 at cycle 3 of a multiply -> state IDLE at cycle 4, no result_valid_o.
   - A div_done arriving in IDLE after a divide abort is ignored.
5. Back-to-back and priority: multiply then divide in consecutive instructions -> divide accepted in the cycle after DONE, two distinct result_valid_o pulses with correct rd. start_mult_E and start_div_E both high -> only mult_start pulses.
6. Reset mid-operation: rst_n=0 during DIV_WAIT -> all outputs 0 immediately (asynchronous, not waiting for a clock edge), state IDLE after release.
